// File: rtl/sap_out_display.sv
// sap_out_display: converts each OUT-register byte to 3-digit BCD by double-dabble
// and scans it onto three multiplexed 7-segment digits with leading-zero blanking.
module sap_out_display #(
  parameter int REFRESH_DIV    = 1024,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  out_val,
  input  logic        out_valid,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [2:0]  an
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [15:0] RC_MAX  = 16'(REFRESH_DIV - 1);
  localparam logic [6:0]  SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [6:0]  SEG_INV = {7{SEG_ACTIVE_LOW}};
  state_t      state_q, state_d;
  logic        busy_q, busy_d, done_q, done_d, pend_q, pend_d;
  logic [11:0] bcd_q, bcd_d, scr_q, scr_d, adj;
  logic [7:0]  val_q, val_d, pval_q, pval_d;
  logic [2:0]  cnt_q, cnt_d, an_q, an_d, an_sel;
  logic [19:0] shifted;
  logic [15:0] rc_q, rc_d;
  logic [1:0]  dig_q, dig_d, dig_n;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  nib;
  logic        wrap, blank;
  function automatic logic [3:0] add3(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'd0: enc = 7'h3F;
      4'd1: enc = 7'h06;
      4'd2: enc = 7'h5B;
      4'd3: enc = 7'h4F;
      4'd4: enc = 7'h66;
      4'd5: enc = 7'h6D;
      4'd6: enc = 7'h7D;
      4'd7: enc = 7'h07;
      4'd8: enc = 7'h7F;
      4'd9: enc = 7'h6F;
      default: enc = 7'h00;
    endcase
  endfunction
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    val_d   = val_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pval_d  = pval_q;
    adj     = {add3(scr_q[11:8]), add3(scr_q[7:4]), add3(scr_q[3:0])};
    shifted = {adj, val_q} << 1;
    // strobes arriving mid-conversion park here; newest wins
    if (state_q != IDLE && out_valid) begin
      pend_d = 1'b1;
      pval_d = out_val;
    end
    case (state_q)
      IDLE: if (out_valid || pend_q) begin
        val_d   = out_valid ? out_val : pval_q;
        pend_d  = 1'b0;
        scr_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        {scr_d, val_d} = shifted;
        cnt_d   = cnt_q + 3'd1;
        state_d = cnt_q == 3'd7 ? DONE : SHIFT;
      end
      DONE: begin
        bcd_d   = scr_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    wrap   = rc_q == RC_MAX;
    rc_d   = wrap ? '0 : rc_q + 16'd1;
    dig_n  = dig_q == 2'd2 ? 2'd0 : dig_q + 2'd1;
    dig_d  = wrap ? dig_n : dig_q;
    nib    = dig_n == 2'd0 ? bcd_q[3:0] : dig_n == 2'd1 ? bcd_q[7:4] : bcd_q[11:8];
    blank  = (dig_n == 2'd2 && bcd_q[11:8] == 4'd0) || (dig_n == 2'd1 && bcd_q[11:4] == 8'd0);
    an_sel = 3'b001 << dig_n;
    an_d   = wrap ? (SEG_ACTIVE_LOW ? ~an_sel : an_sel) : an_q;
    seg_d  = wrap ? (blank ? SEG_OFF : enc(nib) ^ SEG_INV) : seg_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      val_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      pval_q  <= '0;
      rc_q    <= '0;
      dig_q   <= '0;
      an_q    <= SEG_ACTIVE_LOW ? 3'b110 : 3'b001;
      seg_q   <= SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      val_q   <= val_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
      rc_q    <= rc_d;
      dig_q   <= dig_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign seg  = seg_q;
  assign an   = an_q;
endmodule
